// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: FSM states, register names and
// load funct3 encodings.
package writeback_pkg;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/writeback_load_ext.sv
// Combinational load extractor: selects the byte/halfword lane from an
// aligned memory word and sign- or zero-extends it to W bits.
module load_ext
  import writeback_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   addr_lo,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword lane comes from addr_lo[1] only; misaligned bit 0 is ignored.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    value = '0;
    case (funct3)
      LOAD_LB:  value = {{(W-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: value = {{(W-8){1'b0}}, byte_sel};
      LOAD_LH:  value = {{(W-16){half_sel[15]}}, half_sel};
      LOAD_LHU: value = {{(W-16){1'b0}}, half_sel};
      LOAD_LW:  value = rdata;
      default:  value = '0;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: merges ALU results and one outstanding load onto the
// register-file write port, with a one-entry ALU skid and load-use hazard flag.
module writeback
  import writeback_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         alu_valid,
  input  logic [4:0]   alu_rd,
  input  logic [W-1:0] alu_val,
  input  logic         ld_req,
  input  logic [4:0]   ld_rd,
  input  logic [2:0]   ld_funct3,
  input  logic [1:0]   ld_addr_lo,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  input  logic [4:0]   hz_rs1,
  input  logic [4:0]   hz_rs2,
  output logic         busy,
  output logic         stall,
  output logic         ld_hazard,
  output logic         wen,
  output logic [4:0]   rd,
  output logic [W-1:0] rd_val
);

  wb_state_e    state_q, state_d;
  logic [4:0]   pend_rd_q, pend_rd_d;
  logic [2:0]   pend_f3_q, pend_f3_d;
  logic [1:0]   pend_lo_q, pend_lo_d;
  logic         skid_valid_q, skid_valid_d;
  logic [4:0]   skid_rd_q, skid_rd_d;
  logic [W-1:0] skid_val_q, skid_val_d;
  logic         wen_q, wen_d;
  logic         wen_load_q, wen_load_d;
  logic [4:0]   rd_q, rd_d;
  logic [W-1:0] rd_val_q, rd_val_d;

  logic [W-1:0] ld_value;
  logic         load_done;
  logic         alu_take;

  load_ext #(.W(W)) u_load_ext (
    .funct3  (pend_f3_q),
    .addr_lo (pend_lo_q),
    .rdata   (mem_rdata),
    .value   (ld_value)
  );

  assign load_done = (state_q == WB_WAIT) && mem_rvalid;
  // ALU input offered while the skid is full is a protocol violation; drop it.
  assign alu_take  = alu_valid && !skid_valid_q;

  always_comb begin
    state_d      = state_q;
    pend_rd_d    = pend_rd_q;
    pend_f3_d    = pend_f3_q;
    pend_lo_d    = pend_lo_q;
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_val_d   = skid_val_q;
    wen_d        = 1'b0;
    wen_load_d   = 1'b0;
    rd_d         = rd_q;
    rd_val_d     = rd_val_q;

    case (state_q)
      WB_IDLE: begin
        if (ld_req) begin
          pend_rd_d = ld_rd;
          pend_f3_d = ld_funct3;
          pend_lo_d = ld_addr_lo;
          state_d   = WB_WAIT;
        end
      end
      WB_WAIT: begin
        if (mem_rvalid) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase

    // Write-port priority: load data, then skid, then a fresh ALU result.
    if (load_done) begin
      if (pend_rd_q != REG_ZERO) begin
        wen_d      = 1'b1;
        wen_load_d = 1'b1;
        rd_d       = pend_rd_q;
        rd_val_d   = ld_value;
      end
      skid_valid_d = alu_take;
      skid_rd_d    = alu_rd;
      skid_val_d   = alu_val;
    end else if (skid_valid_q) begin
      if (skid_rd_q != REG_ZERO) begin
        wen_d    = 1'b1;
        rd_d     = skid_rd_q;
        rd_val_d = skid_val_q;
      end
      skid_valid_d = 1'b0;
    end else if (alu_take && (alu_rd != REG_ZERO)) begin
      wen_d    = 1'b1;
      rd_d     = alu_rd;
      rd_val_d = alu_val;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= WB_IDLE;
      pend_rd_q    <= '0;
      pend_f3_q    <= '0;
      pend_lo_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_val_q   <= '0;
      wen_q        <= 1'b0;
      wen_load_q   <= 1'b0;
      rd_q         <= '0;
      rd_val_q     <= '0;
    end else begin
      state_q      <= state_d;
      pend_rd_q    <= pend_rd_d;
      pend_f3_q    <= pend_f3_d;
      pend_lo_q    <= pend_lo_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_val_q   <= skid_val_d;
      wen_q        <= wen_d;
      wen_load_q   <= wen_load_d;
      rd_q         <= rd_d;
      rd_val_q     <= rd_val_d;
    end
  end

  assign busy   = (state_q == WB_WAIT);
  assign stall  = skid_valid_q;
  assign wen    = wen_q;
  assign rd     = rd_q;
  assign rd_val = rd_val_q;

  // pend_rd_q still names the load during its write cycle, so it covers both terms.
  assign ld_hazard = (busy || wen_load_q) && (pend_rd_q != REG_ZERO) &&
                     ((hz_rs1 == pend_rd_q) || (hz_rs2 == pend_rd_q));

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback: ALU path, load extension,
// collision skid, hazards, protocol corner cases and reset mid-load.
module tb_writeback;

  logic        clk;
  logic        rstn;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_val;
  logic        ld_req;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  hz_rs1;
  logic [4:0]  hz_rs2;
  logic        busy;
  logic        stall;
  logic        ld_hazard;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] rd_val;

  int n_cmp = 0;
  int n_bad = 0;

  writeback #(.W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_val    (alu_val),
    .ld_req     (ld_req),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hz_rs1     (hz_rs1),
    .hz_rs2     (hz_rs2),
    .busy       (busy),
    .stall      (stall),
    .ld_hazard  (ld_hazard),
    .wen        (wen),
    .rd         (rd),
    .rd_val     (rd_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("chk %-14s obs=0x%08h exp=0x%08h ok", tag, obs, exp);
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input string tag, input logic [4:0] r, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] data,
                          input logic [31:0] exp);
    ld_req = 1'b1; ld_rd = r; ld_funct3 = f3; ld_addr_lo = lo;
    step();
    ld_req = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = data;
    step();
    mem_rvalid = 1'b0;
    chk({tag, "_wen"}, {31'd0, wen}, 32'd1);
    chk({tag, "_rd"}, {27'd0, rd}, {27'd0, r});
    chk({tag, "_val"}, rd_val, exp);
  endtask

  initial begin
    rstn = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_val = '0;
    ld_req = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; hz_rs1 = '0; hz_rs2 = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_rdval", rd_val, 32'd0);
    step();
    rstn = 1'b1;

    // ALU path
    alu_valid = 1'b1; alu_rd = 5'd5; alu_val = 32'h1234;
    step();
    alu_valid = 1'b0;
    chk("alu_wen", {31'd0, wen}, 32'd1);
    chk("alu_rd", {27'd0, rd}, 32'd5);
    chk("alu_val", rd_val, 32'h1234);
    step();
    chk("alu_wen_off", {31'd0, wen}, 32'd0);
    chk("alu_rd_hold", {27'd0, rd}, 32'd5);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_val = 32'h99;
    step();
    alu_valid = 1'b0;
    chk("alu_x0_wen", {31'd0, wen}, 32'd0);
    chk("alu_x0_hold", rd_val, 32'h1234);

    // Load extension
    load_vec("lb3",  5'd10, 3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80);
    load_vec("lbu1", 5'd11, 3'b100, 2'd1, 32'h80FF7F01, 32'h0000007F);
    load_vec("lh1",  5'd12, 3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF);
    load_vec("lhu0", 5'd13, 3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01);
    load_vec("lw",   5'd14, 3'b010, 2'd0, 32'h80FF7F01, 32'h80FF7F01);
    load_vec("f3_011", 5'd15, 3'b011, 2'd0, 32'h80FF7F01, 32'h00000000);
    load_vec("lh_odd", 5'd16, 3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF);

    // Collision
    ld_req = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    step();
    ld_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hAA;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_val = 32'h55;
    step();
    mem_rvalid = 1'b0; alu_valid = 1'b0;
    chk("col_ld_rd", {27'd0, rd}, 32'd7);
    chk("col_ld_val", rd_val, 32'hAA);
    chk("col_stall1", {31'd0, stall}, 32'd1);
    step();
    chk("col_sk_wen", {31'd0, wen}, 32'd1);
    chk("col_sk_rd", {27'd0, rd}, 32'd8);
    chk("col_sk_val", rd_val, 32'h55);
    chk("col_stall0", {31'd0, stall}, 32'd0);
    step();
    chk("col_wen_off", {31'd0, wen}, 32'd0);

    // Hazard
    hz_rs2 = 5'd9;
    chk("hz_before", {31'd0, ld_hazard}, 32'd0);
    ld_req = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010;
    step();
    ld_req = 1'b0;
    chk("hz_pending", {31'd0, ld_hazard}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111;
    step();
    mem_rvalid = 1'b0;
    chk("hz_wr_wen", {31'd0, wen}, 32'd1);
    chk("hz_wr_cycle", {31'd0, ld_hazard}, 32'd1);
    step();
    chk("hz_after", {31'd0, ld_hazard}, 32'd0);
    hz_rs1 = 5'd0; hz_rs2 = 5'd0;
    ld_req = 1'b1; ld_rd = 5'd0;
    step();
    ld_req = 1'b0;
    chk("hz_x0_busy", {31'd0, busy}, 32'd1);
    chk("hz_x0", {31'd0, ld_hazard}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h2222;
    step();
    mem_rvalid = 1'b0;
    chk("x0_ld_wen", {31'd0, wen}, 32'd0);
    chk("x0_ld_busy", {31'd0, busy}, 32'd0);

    // Protocol: second ld_req while busy, rvalid in IDLE
    ld_req = 1'b1; ld_rd = 5'd20; ld_funct3 = 3'b010;
    step();
    ld_rd = 5'd21;
    step();
    ld_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h33;
    step();
    mem_rvalid = 1'b0;
    chk("dup_rd", {27'd0, rd}, 32'd20);
    chk("dup_val", rd_val, 32'h33);
    chk("dup_busy", {31'd0, busy}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    step();
    mem_rvalid = 1'b0;
    chk("idle_rv_wen", {31'd0, wen}, 32'd0);
    chk("idle_rv_busy", {31'd0, busy}, 32'd0);

    // Reset mid-load
    ld_req = 1'b1; ld_rd = 5'd22;
    step();
    ld_req = 1'b0;
    chk("rml_busy", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rml_async", {31'd0, busy}, 32'd0);
    step();
    rstn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    step();
    mem_rvalid = 1'b0;
    chk("rml_wen", {31'd0, wen}, 32'd0);
    chk("rml_rd", {27'd0, rd}, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
